tile_map_ctrl: RTL and testbench

//  Owns the 4x4 brick map consumed by the board drawing stage. It is the writer side of the tile state.
//  The ball controller submits ball positions over a valid/ready request. The block scans all tiles
//  for overlap, destroys the first hit, and returns hit/index/bounce side. It drives tiles_alive,

---
 rtl/tile_map_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tile_map_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_ctrl.sv
// 4x4 brick map owner: scans one tile per cycle for ball overlap, kills the lowest alive hit, reports side.
// Optional build macro TILE_MAP_MULTIHIT_EN: two strikes per tile, adds tiles_cracked output.
module tile_map_ctrl #(
  parameter int X0        = 282,
  parameter int Y0        = 100,
  parameter int TILE_W    = 81,
  parameter int TILE_H    = 21,
  parameter int PITCH_X   = 100,
  parameter int PITCH_Y   = 40,
  parameter int BALL_SIZE = 8,
  parameter int SCORE_W   = 8
) (
  input  logic               pclk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [10:0]        ball_x,
  input  logic [10:0]        ball_y,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_hit,
  output logic [3:0]         resp_idx,
  output logic               resp_side,
  input  logic               restore,
  output logic [15:0]        tiles_alive,
  output logic [SCORE_W-1:0] score,
  output logic               board_clear
`ifdef TILE_MAP_MULTIHIT_EN
  ,
  output logic [15:0]        tiles_cracked
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t      state, state_nxt;
  logic [11:0] bx, by;
  logic [3:0]  idx;
  logic        found;
  logic [3:0]  best_idx;
  logic        restore_pend;

  logic        accept, scan_last, enter_idle, do_restore;
  logic [11:0] cur_tx, cur_ty, fin_ty, cy;
  logic        cur_hit, fin_hit, fin_side, kill;
  logic [3:0]  fin_idx;

`ifdef TILE_MAP_MULTIHIT_EN
  logic [1:0]  hit_cnt [16];
`endif

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = SCAN;
      SCAN:    if (idx == 4'd15) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    accept     = (state == IDLE) && req_valid;
    scan_last  = (state == SCAN) && (idx == 4'd15);
    enter_idle = (state == RESP) && resp_ready;
    do_restore = ((state == IDLE) && restore) || (enter_idle && (restore || restore_pend));
  end

  // Overlap of the ball box with the tile under evaluation; 12-bit math avoids edge wrap.
  always_comb begin
    cur_tx  = 12'(X0 + int'(idx[1:0]) * PITCH_X);
    cur_ty  = 12'(Y0 + int'(idx[3:2]) * PITCH_Y);
    cur_hit = tiles_alive[idx] &&
              (bx <= cur_tx + 12'(TILE_W - 1)) && (bx + 12'(BALL_SIZE - 1) >= cur_tx) &&
              (by <= cur_ty + 12'(TILE_H - 1)) && (by + 12'(BALL_SIZE - 1) >= cur_ty);
    fin_hit  = found || cur_hit;
    fin_idx  = found ? best_idx : (cur_hit ? idx : 4'd0);
    fin_ty   = 12'(Y0 + int'(fin_idx[3:2]) * PITCH_Y);
    cy       = by + 12'(BALL_SIZE / 2);
    fin_side = fin_hit && (cy >= fin_ty) && (cy <= fin_ty + 12'(TILE_H - 1));
`ifdef TILE_MAP_MULTIHIT_EN
    kill = fin_hit && (hit_cnt[fin_idx] == 2'd1);
`else
    kill = fin_hit;
`endif
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      bx       <= '0;
      by       <= '0;
      idx      <= '0;
      found    <= 1'b0;
      best_idx <= '0;
    end else if (accept) begin
      bx       <= {1'b0, ball_x};
      by       <= {1'b0, ball_y};
      idx      <= '0;
      found    <= 1'b0;
      best_idx <= '0;
    end else if (state == SCAN) begin
      idx <= idx + 4'd1;
      if (!found && cur_hit) begin
        found    <= 1'b1;
        best_idx <= idx;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_idx   <= '0;
      resp_side  <= 1'b0;
    end else if (scan_last) begin
      resp_valid <= 1'b1;
      resp_hit   <= fin_hit;
      resp_idx   <= fin_idx;
      resp_side  <= fin_side;
    end else if (enter_idle) begin
      resp_valid <= 1'b0;
    end
  end

  // A restore outside IDLE waits so the in-flight strike lands before the board is refilled.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n)              restore_pend <= 1'b0;
    else if (enter_idle)       restore_pend <= 1'b0;
    else if (restore && state != IDLE) restore_pend <= 1'b1;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      tiles_alive <= 16'hFFFF;
      score       <= '0;
      board_clear <= 1'b0;
    end else begin
      board_clear <= (tiles_alive == 16'h0000);
      if (do_restore) begin
        tiles_alive <= 16'hFFFF;
      end else if (scan_last && kill) begin
        tiles_alive[fin_idx] <= 1'b0;
        if (score != {SCORE_W{1'b1}}) score <= score + 1'b1;
      end
    end
  end

`ifdef TILE_MAP_MULTIHIT_EN
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) hit_cnt[i] <= 2'd2;
    end else if (do_restore) begin
      for (int i = 0; i < 16; i++) hit_cnt[i] <= 2'd2;
    end else if (scan_last && fin_hit) begin
      hit_cnt[fin_idx] <= hit_cnt[fin_idx] - 2'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) tiles_cracked[i] = tiles_alive[i] && (hit_cnt[i] == 2'd1);
  end
`endif

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Directed bench for tile_map_ctrl with a geometric board model and a per-cycle compare process.
module tb_tile_map_ctrl;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] ball_x = '0;
  logic [10:0] ball_y = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_hit;
  logic [3:0]  resp_idx;
  logic        resp_side;
  logic        restore = 1'b0;
  logic [15:0] tiles_alive;
  logic [7:0]  score;
  logic        board_clear;

  tile_map_ctrl dut (
    .pclk(pclk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .ball_x(ball_x), .ball_y(ball_y), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_idx(resp_idx), .resp_side(resp_side), .restore(restore),
    .tiles_alive(tiles_alive), .score(score), .board_clear(board_clear)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Board model: which bricks stand, how many were destroyed, what the pending response must be.
  bit   m_alive [16];
  int   m_score;
  bit   exp_hit, exp_side, exp_rv, exp_rdy, pend, chk_en, clr_exp;
  int   exp_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alive_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_alive[i];
    return v;
  endfunction

  function automatic void model_resp(input int bx, input int by, output bit hit, output int idx,
                                     output bit side);
    hit = 0; idx = 0; side = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int tx, ty;
        tx = 282 + 100 * c;
        ty = 100 + 40 * r;
        if (!hit && m_alive[r*4+c] && bx <= tx + 80 && bx + 7 >= tx && by <= ty + 20 && by + 7 >= ty) begin
          hit  = 1;
          idx  = r * 4 + c;
          side = (by + 4 >= ty) && (by + 4 <= ty + 20);
        end
      end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_alive[i] = 1;
    m_score = 0; exp_rv = 0; exp_rdy = 1; pend = 0;
  endtask

  always @(posedge pclk or negedge reset_n)
    if (!reset_n) clr_exp <= 1'b0;
    else          clr_exp <= (alive_vec() == 16'h0000);

  always @(negedge pclk) begin
    if (chk_en) begin
      check("tiles_alive", tiles_alive, alive_vec());
      check("score", score, (m_score > 255) ? 255 : m_score);
      check("board_clear", board_clear, clr_exp);
      check("req_ready", req_ready, exp_rdy);
      check("resp_valid", resp_valid, exp_rv);
      if (resp_valid) begin
        check("resp_hit", resp_hit, exp_hit);
        check("resp_idx", resp_idx, exp_idx);
        check("resp_side", resp_side, exp_side);
      end
    end
  end

  // Issue a request and wait for the committed response; restore_at>=1 pulses restore mid-scan.
  task automatic send_req(input int bx, input int by, input int restore_at);
    int lat;
    @(negedge pclk);
    req_valid = 1'b1; ball_x = 11'(bx); ball_y = 11'(by);
    model_resp(bx, by, exp_hit, exp_idx, exp_side);
    @(posedge pclk); #1;
    req_valid = 1'b0; exp_rdy = 0;
    lat = 0;
    while (1) begin
      if (lat == restore_at) begin restore = 1'b1; pend = 1; end
      @(posedge pclk); #1;
      restore = 1'b0;
      lat++;
      if (resp_valid || lat >= 40) break;
    end
    check("latency", lat, 16);
    exp_rv = 1;
    if (exp_hit) begin m_alive[exp_idx] = 0; m_score++; end
  endtask

  task automatic finish_resp(input int hold);
    repeat (hold) @(posedge pclk);
    @(negedge pclk); resp_ready = 1'b1;
    @(posedge pclk); #1;
    resp_ready = 1'b0; exp_rv = 0; exp_rdy = 1;
    if (pend) begin for (int i = 0; i < 16; i++) m_alive[i] = 1; pend = 0; end
    check("resp_drop", resp_valid, 1'b0);
  endtask

  task automatic restore_idle();
    @(negedge pclk); restore = 1'b1;
    @(posedge pclk); #1; restore = 1'b0;
    for (int i = 0; i < 16; i++) m_alive[i] = 1;
  endtask

  task automatic reset_mid_scan();
    @(negedge pclk); req_valid = 1'b1; ball_x = 11'd300; ball_y = 11'd105;
    @(posedge pclk); #1; req_valid = 1'b0; exp_rdy = 0;
    repeat (5) @(posedge pclk);
    #3; chk_en = 0; reset_n = 1'b0; #1;
    check("rst_alive", tiles_alive, 16'hFFFF);
    check("rst_score", score, 0);
    check("rst_rv", resp_valid, 0);
    check("rst_rdy", req_ready, 1);
    check("rst_clear", board_clear, 0);
    check("rst_resp", {resp_hit, resp_idx, resp_side}, 0);
    model_reset();
    @(negedge pclk); reset_n = 1'b1; chk_en = 1;
  endtask

  initial begin
    chk_en = 0;
    model_reset();
    repeat (3) @(posedge pclk);
    @(negedge pclk); reset_n = 1'b1; chk_en = 1;
    @(posedge pclk); #1;
    check("t1_alive", tiles_alive, 16'hFFFF);
    check("t1_score", score, 0);
    check("t1_rdy", req_ready, 1);
    check("t1_rv", resp_valid, 0);
    check("t1_clear", board_clear, 0);

    send_req(300, 95, -1);
    check("t2_resp", {resp_hit, resp_idx, resp_side}, {1'b1, 4'd0, 1'b0});
    finish_resp(0);
    check("t2_alive", tiles_alive, 16'hFFFE);
    check("t2_score", score, 1);

    send_req(300, 95, -1);
    check("t3_hit", resp_hit, 0);
    finish_resp(2);
    check("t3_alive", tiles_alive, 16'hFFFE);

    restore_idle();
    check("t4_restore", tiles_alive, 16'hFFFF);
    send_req(276, 105, -1);
    check("t4_resp", {resp_hit, resp_idx, resp_side}, {1'b1, 4'd0, 1'b1});
    finish_resp(10);
    check("t4_score", score, 2);

    send_req(392, 145, 5);
    check("t5_resp", {resp_hit, resp_idx, resp_side}, {1'b1, 4'd5, 1'b1});
    check("t5_commit", tiles_alive, 16'hFFDE);
    finish_resp(1);
    check("t5_alive", tiles_alive, 16'hFFFF);
    check("t5_score", score, 3);

    send_req(363, 105, -1); finish_resp(0);
    send_req(290, 92, -1);  finish_resp(0);
    send_req(362, 113, -1);
    check("edge_right", {resp_hit, resp_idx, resp_side}, {1'b1, 4'd0, 1'b1});
    finish_resp(0);
    send_req(390, 93, -1);
    check("edge_top", {resp_hit, resp_idx, resp_side}, {1'b1, 4'd1, 1'b0});
    finish_resp(0);

    reset_mid_scan();

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        send_req(292 + 100 * c, 105 + 40 * r, -1);
        check("t6_idx", resp_idx, r * 4 + c);
        if (r == 3 && c == 3) begin
          check("t6_alive", tiles_alive, 16'h0000);
          check("t6_score", score, 16);
          check("t6_clear_lag", board_clear, 0);
          @(posedge pclk); #1;
          check("t6_clear", board_clear, 1);
        end
        finish_resp(0);
      end
    send_req(300, 105, -1);
    check("t6_empty_hit", resp_hit, 0);
    finish_resp(0);

    reset_mid_scan();
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
